// File: rtl/instr_fetch_if.sv
// Handshake bundle between the instruction fetch unit, instruction memory and decoder.
// master: fetch unit side; slave: memory/core environment side.
interface instr_fetch_if;
  logic        in_run;
  logic        out_imem_req;
  logic [31:0] out_imem_addr;
  logic        in_imem_ack;
  logic [31:0] in_imem_data;
  logic [31:0] out_is;
  logic        out_is_valid;
  logic [31:0] out_pc;
  logic        in_accept;
  logic        in_redirect;
  logic [31:0] in_redirect_pc;
  logic        in_syscall;
  logic        out_halted;

  modport master (
    input  in_run,
    input  in_imem_ack,
    input  in_imem_data,
    input  in_accept,
    input  in_redirect,
    input  in_redirect_pc,
    input  in_syscall,
    output out_imem_req,
    output out_imem_addr,
    output out_is,
    output out_is_valid,
    output out_pc,
    output out_halted
  );

  modport slave (
    output in_run,
    output in_imem_ack,
    output in_imem_data,
    output in_accept,
    output in_redirect,
    output in_redirect_pc,
    output in_syscall,
    input  out_imem_req,
    input  out_imem_addr,
    input  out_is,
    input  out_is_valid,
    input  out_pc,
    input  out_halted
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch FSM (IDLE/REQ/HOLD/HALT): one outstanding imem read, holds the word for the decoder.
// Ports: in_clk, in_rst (sync, active-high), bus (instr_fetch_if.master). Macro IFETCH_SYSCALL_HALT_EN enables syscall halt.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          in_clk,
  input  logic          in_rst,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    HALT
  } state_e;

  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] is_q, is_d;
  logic [31:0] opc_q, opc_d;
  logic        valid_q, valid_d;
  logic        req_q, req_d;
  logic [31:0] pc_next;
  logic        sys_halt;
  logic [1:0]  unused_rpc_lo;

  assign unused_rpc_lo = bus.in_redirect_pc[1:0];

`ifdef IFETCH_SYSCALL_HALT_EN
  assign sys_halt       = bus.in_syscall;
  assign bus.out_halted = (state_q == HALT);
`else
  logic unused_syscall;
  assign unused_syscall = bus.in_syscall;
  assign sys_halt       = 1'b0;
  assign bus.out_halted = 1'b0;
`endif

  // Redirect still steers pc even when a syscall halts fetch.
  assign pc_next = bus.in_redirect
                 ? {bus.in_redirect_pc[31:2], 2'b00}
                 : pc_q + 32'd4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    is_d    = is_q;
    opc_d   = opc_q;
    valid_d = valid_q;
    req_d   = req_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_run) begin
          state_d = REQ;
          req_d   = 1'b1;
        end
      end
      // Request stays up until acked; in_run is not looked at here.
      REQ: begin
        if (bus.in_imem_ack) begin
          is_d    = bus.in_imem_data;
          opc_d   = pc_q;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.in_accept) begin
          pc_d    = pc_next;
          valid_d = 1'b0;
          if (sys_halt) begin
            state_d = HALT;
          end else if (bus.in_run) begin
            state_d = REQ;
            req_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= IDLE;
      pc_q    <= PC_INIT;
      is_q    <= '0;
      opc_q   <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      is_q    <= is_d;
      opc_q   <= opc_d;
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  assign bus.out_imem_req  = req_q;
  assign bus.out_imem_addr = pc_q;
  assign bus.out_is        = is_q;
  assign bus.out_pc        = opc_q;
  assign bus.out_is_valid  = valid_q;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, SHALL be the PC loaded on reset; its bits [1:0] SHALL be zero.
REQ-002 Clocking SHALL use one clock, in_clk; reset in_rst SHALL be synchronous and active-high.
REQ-003 in_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 in_rst  input  1  synchronous active-high reset.
REQ-005 in_run  input  1  fetch enable; low SHALL stop new fetches.
REQ-006 out_imem_req  output  1  instruction-memory read request.
REQ-007 out_imem_addr  output  32  word-aligned read address (current PC).
REQ-008 in_imem_ack  input  1  read data valid this cycle.
REQ-009 in_imem_data  input  32  instruction word, sampled when in_imem_ack=1.
REQ-010 out_is  output  32  instruction word presented to the decoder.
REQ-011 out_is_valid  output  1  out_is holds a fetched, unconsumed instruction.
REQ-012 out_pc  output  32  PC of out_is.
REQ-013 in_accept  input  1  core consumes out_is this cycle.
REQ-014 in_redirect  input  1  taken J/JR/branch/eret; qualified only by in_accept.
REQ-015 in_redirect_pc  input  32  redirect target.
REQ-016 in_syscall  input  1  consumed instruction is a syscall; qualified by in_accept.
REQ-017 out_halted  output  1  fetch halted by a syscall.

Function
REQ-018 States SHALL be IDLE, REQ, HOLD and HALT.
REQ-019 IDLE: SHALL move to REQ when in_run=1; out_imem_req=0, out_is_valid=0.
REQ-020 REQ: out_imem_req=1 and out_imem_addr=pc SHALL be held stable until in_imem_ack=1, including the cycle of entry (same-cycle ack is legal).
REQ-021 On in_imem_ack in REQ: out_is<=in_imem_data, out_pc<=pc, out_is_valid=1 from the next cycle; next state HOLD; latency ack-to-valid SHALL be exactly 1 cycle.
REQ-022 in_run falling during REQ SHALL NOT abort the outstanding request; the request completes into HOLD.
REQ-023 HOLD: out_is, out_pc and out_is_valid SHALL stay constant until in_accept=1; out_imem_req=0.
REQ-024 On in_accept in HOLD: pc<={in_redirect_pc[31:2],2'b00} if in_redirect, else pc+4 modulo 2^32 (32'hFFFFFFFC wraps to 0); next state REQ if in_run, else IDLE; out_is_valid SHALL be 0 the following cycle.
REQ-025 in_redirect, in_syscall and in_accept SHALL be ignored in every state except HOLD.
REQ-026 in_imem_ack outside REQ SHALL be ignored.
REQ-027 If redirect and syscall assert together (with the macro enabled), syscall SHALL take precedence; pc SHALL still be updated from the redirect.

Reset
REQ-028 While in_rst=1: state<=IDLE, pc<=RESET_PC, out_is<=0, out_pc<=0, out_is_valid<=0, out_imem_req<=0, out_halted<=0.
REQ-029 Reset mid-request SHALL abandon the request; an ack in the reset cycle SHALL be discarded.
REQ-030 Reset SHALL have priority over every other input.

Configuration
REQ-031 Macro IFETCH_SYSCALL_HALT_EN defined: in_syscall with in_accept in HOLD SHALL move to HALT, out_halted=1, no further requests, until reset.
REQ-032 Macro undefined: in_syscall SHALL be ignored, HALT SHALL be unreachable, out_halted SHALL be tied 0.

Verification
REQ-033 Reset, RESET_PC=0, in_run=1, ack in 1st REQ cycle with 32'h20080005 -> addr 0, next cycle out_is=32'h20080005, out_pc=0, out_is_valid=1.
REQ-034 Accept without redirect at pc=32'hFFFFFFFC -> next request addr 32'h00000000.
REQ-035 Accept with in_redirect=1, in_redirect_pc=32'h00400013 -> next request addr 32'h00400010; redirect asserted while in HOLD without in_accept -> no effect.
REQ-036 Ack delayed 3 cycles, in_run dropped in 2nd cycle -> addr stable all 3 cycles, HOLD reached, IDLE after accept.
REQ-037 Macro defined, accept with in_syscall=1 -> out_halted=1 next cycle, out_imem_req stays 0 for 20 cycles; in_rst -> out_halted=0, state IDLE.
REQ-038 in_rst asserted in REQ with concurrent ack -> out_is_valid=0, pc=RESET_PC after the reset cycle.
